npc_pc_unit: RTL

- Fetch-side consumer of the D-stage branch decision.
- Holds the F-stage program counter and selects the next PC from four sources: sequential, conditional branch (taken flag from the D-stage comparator), j/jal absolute, and jr register target.
- Supports MIPS delay-slot semantics, hazard-unit stalls and a sticky misaligned-jr flag.
- Keeps 32-bit saturating branch-resolved and branch-taken counters, readable as debug outputs.

---
 rtl/npc_pc_unit_pkg.sv | 30 +++
 rtl/npc_pc_unit_sat_counter.sv | 25 ++
 rtl/npc_pc_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/npc_pc_unit_pkg.sv
// Shared definitions for the fetch-side next-PC unit: the npc_op encodings
// used by the D-stage controller, the default fetch PC after reset, and small
// helpers that build branch and jump targets.
package npc_pc_unit_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_op_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    // Branch target relative to the delay slot: pc_d + 4 + (sext(imm16) << 2).
    // The sum wraps modulo 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc_d,
                                                  input logic [15:0] imm16);
        logic [31:0] offset;
        offset = {{14{imm16[15]}}, imm16, 2'b00};
        return pc_d + 32'd4 + offset;
    endfunction

    // j/jal target: the 256 MB region comes from the D-stage PC, not from pc_f.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_d,
                                                input logic [25:0] index26);
        return {pc_d[31:28], index26, 2'b00};
    endfunction

endpackage

// File: rtl/npc_pc_unit_sat_counter.sv
// Saturating up-counter: increments on en, sticks at all-ones instead of
// wrapping, and clears on a synchronous reset.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic at_max;

    assign at_max = &count;

    // Count enabled events until the counter reaches all-ones, then hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/npc_pc_unit.sv
// Fetch program counter with next-PC selection.
// The D-stage decision (sequential, conditional branch, j/jal, jr) picks the
// next fetch address. The instruction already in F when the branch sits in D
// is the delay slot and is never squashed, so a redirect simply becomes the
// fetch after it. Stalls freeze the PC, the branch statistics and the sticky
// jr alignment flag; the D inputs are re-evaluated each cycle, so nothing is
// latched while stalled.
module npc_pc_unit
    import npc_pc_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       npc_op,
    input  logic             br_true,
    input  logic [31:0]      pc_d,
    input  logic [15:0]      imm16,
    input  logic [25:0]      index26,
    input  logic [31:0]      jr_target,
    output logic [31:0]      pc_f,
    output logic [31:0]      pc8_d,
    output logic             redirect,
    output logic             jr_misalign,
    output logic [CNT_W-1:0] br_total,
    output logic [CNT_W-1:0] br_taken
);

    npc_op_e     op;
    logic [31:0] pc_seq;
    logic [31:0] npc;
    logic        advance;
    logic        br_resolve;
    logic        br_take;
    logic        jr_bad;

    assign op      = npc_op_e'(npc_op);
    assign pc_seq  = pc_f + 32'd4;
    assign pc8_d   = pc_d + 32'd8;
    assign advance = !stall;

    // Next-PC mux and redirect flag; br_true only matters for a branch.
    always_comb begin
        npc      = pc_seq;
        redirect = 1'b0;
        case (op)
            NPC_SEQ: begin
                npc      = pc_seq;
                redirect = 1'b0;
            end
            NPC_BR: begin
                if (br_true) begin
                    npc      = branch_target(pc_d, imm16);
                    redirect = 1'b1;
                end else begin
                    npc      = pc_seq;
                    redirect = 1'b0;
                end
            end
            NPC_J: begin
                npc      = jump_target(pc_d, index26);
                redirect = 1'b1;
            end
            NPC_JR: begin
                npc      = {jr_target[31:2], 2'b00};
                redirect = 1'b1;
            end
            default: begin
                npc      = pc_seq;
                redirect = 1'b0;
            end
        endcase
    end

    // Fetch PC register: reset wins over stall and redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f <= PC_RESET;
        end else if (advance) begin
            pc_f <= npc;
        end
    end

    assign jr_bad = (op == NPC_JR) && (jr_target[1:0] != 2'b00);

    // Sticky misaligned-jr flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            jr_misalign <= 1'b0;
        end else if (advance && jr_bad) begin
            jr_misalign <= 1'b1;
        end
    end

    // A branch counts as resolved only on the edge that actually consumes it,
    // so a stalled branch is counted once, on release. Both counters saturate
    // independently; taken saturates no earlier than total, so taken <= total.
    assign br_resolve = advance && (op == NPC_BR);
    assign br_take    = br_resolve && br_true;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_br_total (
        .clk   (clk),
        .reset (reset),
        .en    (br_resolve),
        .count (br_total)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_br_taken (
        .clk   (clk),
        .reset (reset),
        .en    (br_take),
        .count (br_taken)
    );

endmodule
